// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl_if
// Description : Button inputs and datapath control outputs of the stopwatch
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
    logic       S1;
    logic       S2;
    logic       count_en;
    logic       count_clr;
    logic       disp_hold;
    logic       running;
    logic [1:0] state;

    modport slave (
        input  S1,
        input  S2,
        output count_en,
        output count_clr,
        output disp_hold,
        output running,
        output state
    );

    modport master (
        output S1,
        output S2,
        input  count_en,
        input  count_clr,
        input  disp_hold,
        input  running,
        input  state
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Button conditioning, start/stop/lap/clear FSM and tenth-second
//               count-enable prescaler for the stopwatch datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int TICK_DIV = 5000000,
    parameter int LOCKOUT  = 2
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    stopwatch_ctrl_if.slave  sw
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int LW = $clog2(LOCKOUT + 1);

    localparam logic [PW-1:0] c_TMAX = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] c_LOCK = LW'(LOCKOUT);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_RUN  = 2'b01;
    localparam logic [1:0] c_STOP = 2'b10;
    localparam logic [1:0] c_LAP  = 2'b11;

    logic [1:0]    w_btn;
    logic [1:0]    w_raw;
    logic          w_s1;
    logic          w_s2;
    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic          w_to_idle;
    logic          w_running;
    logic          r_clr;
    logic [PW-1:0] r_presc;

    assign w_btn = {sw.S2, sw.S1};

    // Flops reset to 0 ("pressed") so a button held through reset never
    // yields a falling edge until it has been released first.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_btn
        logic          r_sync1;
        logic          r_sync2;
        logic          r_prev;
        logic [LW-1:0] r_lock;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_prev  <= 1'b0;
                r_lock  <= '0;
            end else begin
                r_sync1 <= w_btn[gi];
                r_sync2 <= r_sync1;
                r_prev  <= r_sync2;
                if (w_raw[gi])
                    r_lock <= c_LOCK;
                else if (r_lock != '0)
                    r_lock <= r_lock - LW'(1);
            end
        end

        assign w_raw[gi] = r_prev & ~r_sync2 & (r_lock == '0);
    end

    // S1 has priority; a coincident S2 press is dropped but still locks out.
    assign w_s1 = w_raw[0];
    assign w_s2 = w_raw[1] & ~w_raw[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_clr   <= w_to_idle;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (w_s1) w_next = c_RUN;
            c_RUN:  if (w_s1) w_next = c_STOP; else if (w_s2) w_next = c_LAP;
            c_LAP:  if (w_s1) w_next = c_STOP; else if (w_s2) w_next = c_RUN;
            c_STOP: if (w_s1) w_next = c_RUN;  else if (w_s2) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // IDLE->IDLE on S2 counts as a transition into IDLE.
    assign w_to_idle = (w_s1 | w_s2) & (w_next == c_IDLE);
    assign w_running = (r_state == c_RUN) | (r_state == c_LAP);

    // STOP holds the prescaler so a resume keeps the partial tenth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_presc <= '0;
        else if (w_to_idle)
            r_presc <= '0;
        else if (w_running)
            r_presc <= (r_presc == c_TMAX) ? '0 : r_presc + PW'(1);
    end

    always_comb begin
        sw.state     = r_state;
        sw.running   = w_running;
        sw.disp_hold = (r_state == c_LAP);
        sw.count_clr = r_clr;
        sw.count_en  = w_running & (r_presc == c_TMAX);
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed self-checking bench for stopwatch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    stopwatch_ctrl_if swif ();

    stopwatch_ctrl #(
        .TICK_DIV (4),
        .LOCKOUT  (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sw     (swif)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Buttons low for one edge, then released; returns just after edge 3.
    task automatic press(input logic b1, input logic b2);
        swif.S1 = ~b1;
        swif.S2 = ~b2;
        tick(1);
        swif.S1 = 1'b1;
        swif.S2 = 1'b1;
        tick(2);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        tick(3);
        n_checks++;
        if ({swif.state, swif.count_en, swif.count_clr, swif.disp_hold, swif.running} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {swif.state, swif.count_en, swif.count_clr, swif.disp_hold, swif.running});
        end
        resetn = 1'b1;
        tick(4);
        n_checks++;
        if (swif.state !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_idle: got %0d expected 0", swif.state);
        end
        n_checks++;
        if (swif.count_clr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_clr: got %0d expected 0", swif.count_clr);
        end
    endtask

    task automatic test_run;
        int pulses;
        int first;
        int holds;
        press(1'b1, 1'b0);
        n_checks++;
        if (swif.state !== 2'b01 || swif.running !== 1'b1 || swif.count_en !== 1'b0) begin
            n_errors++;
            $display("FAIL run_entry: got state=%0d run=%0d en=%0d expected 1 1 0",
                     swif.state, swif.running, swif.count_en);
        end
        pulses = 0;
        first  = -1;
        holds  = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (swif.count_en === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (swif.disp_hold !== 1'b0) holds++;
        end
        n_checks++;
        if (pulses !== 10) begin
            n_errors++;
            $display("FAIL run_pulses: got %0d expected 10", pulses);
        end
        n_checks++;
        if (first !== 3) begin
            n_errors++;
            $display("FAIL run_first_en: got %0d expected 3", first);
        end
        n_checks++;
        if (holds !== 0) begin
            n_errors++;
            $display("FAIL run_disp_hold: got %0d expected 0", holds);
        end
    endtask

    task automatic test_lap;
        int pulses;
        press(1'b0, 1'b1);
        n_checks++;
        if (swif.state !== 2'b11 || swif.disp_hold !== 1'b1 || swif.running !== 1'b1) begin
            n_errors++;
            $display("FAIL lap_entry: got state=%0d hold=%0d run=%0d expected 3 1 1",
                     swif.state, swif.disp_hold, swif.running);
        end
        n_checks++;
        if (swif.count_en !== 1'b1) begin
            n_errors++;
            $display("FAIL lap_en_phase: got %0d expected 1", swif.count_en);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (swif.count_en === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 2) begin
            n_errors++;
            $display("FAIL lap_pulses: got %0d expected 2", pulses);
        end
        press(1'b0, 1'b1);
        n_checks++;
        if (swif.state !== 2'b01 || swif.disp_hold !== 1'b0) begin
            n_errors++;
            $display("FAIL lap_exit: got state=%0d hold=%0d expected 1 0",
                     swif.state, swif.disp_hold);
        end
    endtask

    task automatic test_stop_resume;
        int pulses;
        press(1'b1, 1'b0);
        n_checks++;
        if (swif.state !== 2'b10 || swif.count_en !== 1'b0 || swif.running !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_entry: got state=%0d en=%0d run=%0d expected 2 0 0",
                     swif.state, swif.count_en, swif.running);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (swif.count_en === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL stop_no_en: got %0d expected 0", pulses);
        end
        press(1'b1, 1'b0);
        n_checks++;
        if (swif.state !== 2'b01 || swif.count_en !== 1'b0) begin
            n_errors++;
            $display("FAIL resume_entry: got state=%0d en=%0d expected 1 0",
                     swif.state, swif.count_en);
        end
        tick(1);
        n_checks++;
        if (swif.count_en !== 1'b0) begin
            n_errors++;
            $display("FAIL resume_en_early: got %0d expected 0", swif.count_en);
        end
        tick(1);
        n_checks++;
        if (swif.count_en !== 1'b1) begin
            n_errors++;
            $display("FAIL resume_partial: got %0d expected 1", swif.count_en);
        end
    endtask

    task automatic test_clear;
        int en_cnt;
        int clr_cnt;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        n_checks++;
        if (swif.state !== 2'b00 || swif.count_clr !== 1'b1 || swif.count_en !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_entry: got state=%0d clr=%0d en=%0d expected 0 1 0",
                     swif.state, swif.count_clr, swif.count_en);
        end
        tick(1);
        chk("clear_one_cycle", int'(swif.count_clr), 0);
        press(1'b0, 1'b1);
        chk("reclear_pulse", int'(swif.count_clr), 1);
        chk("reclear_state", int'(swif.state), 0);
        en_cnt  = 0;
        clr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (swif.count_en === 1'b1) en_cnt++;
            if (swif.count_clr === 1'b1) clr_cnt++;
        end
        chk("idle_no_en", en_cnt, 0);
        chk("idle_no_extra_clr", clr_cnt, 0);
    endtask

    task automatic test_back_to_back;
        press(1'b1, 1'b1);
        chk("simul_s1_wins", int'(swif.state), 1);
        tick(3);
        // 1-0-1-0 glitch: second falling edge lands inside the lockout window
        swif.S1 = 1'b0;
        tick(1);
        swif.S1 = 1'b1;
        tick(1);
        swif.S1 = 1'b0;
        tick(1);
        swif.S1 = 1'b1;
        tick(6);
        chk("glitch_single", int'(swif.state), 2);
    endtask

    task automatic test_reset_hold;
        resetn = 1'b0;
        swif.S1 = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(5);
        chk("held_through_reset", int'(swif.state), 0);
        swif.S1 = 1'b1;
        tick(4);
        chk("release_no_press", int'(swif.state), 0);
        press(1'b1, 1'b0);
        chk("repress_run", int'(swif.state), 1);
        tick(3);
        chk("pre_reset_en", int'(swif.count_en), 1);
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({swif.state, swif.count_en, swif.count_clr, swif.disp_hold, swif.running} !== 6'b0) begin
            n_errors++;
            $display("FAIL async_reset: got %b expected 000000",
                     {swif.state, swif.count_en, swif.count_clr, swif.disp_hold, swif.running});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk      = 1'b0;
        resetn   = 1'b0;
        swif.S1  = 1'b1;
        swif.S2  = 1'b1;
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_run();
        test_lap();
        test_stop_resume();
        test_clear();
        test_back_to_back();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
